systolic_mac_array: RTL

Output-stationary SIZE×SIZE systolic multiply-accumulate array computing C = A·B. It consumes two skewed wavefront streams, one per operand, in the exact format produced by the shiftMatrix stage: A enters from the left edge and B enters from the top edge. It accumulates each product term in place and presents the full C matrix once the array has drained. It sits directly downstream of the shiftMatrix instances and upstream of result readout.

---
 rtl/systolic_mac_array.sv | 133 +++++++++++++
 1 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary SIZE x SIZE systolic MAC array computing C = A*B from skewed
// A (left edge) and B (top edge) wavefronts; C is read directly from the PE accumulators.
module systolic_mac_array #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3,
  parameter int ACC_W = 2*WIDTH + $clog2(SIZE)
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SIZE*WIDTH-1:0]       a_in,
  input  logic [SIZE*WIDTH-1:0]       b_in,
  output logic                        busy,
  output logic                        done,
  output logic [SIZE*SIZE*ACC_W-1:0]  c_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(2*SIZE-1);
  localparam logic [CW-1:0] LAST_WF = CW'(2*SIZE-2);
  localparam logic [CW-1:0] LAST_DR = CW'(SIZE-2);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a   [SIZE][SIZE];
  logic [WIDTH-1:0] r_b   [SIZE][SIZE];
  logic [ACC_W-1:0] r_acc [SIZE][SIZE];

  logic [WIDTH-1:0]   w_a_lane [SIZE];
  logic [WIDTH-1:0]   w_b_lane [SIZE];
  logic [WIDTH-1:0]   w_a_into [SIZE][SIZE];
  logic [WIDTH-1:0]   w_b_into [SIZE][SIZE];
  logic [2*WIDTH-1:0] w_prod   [SIZE][SIZE];
  logic               w_adv;

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_adv    = (r_state == S_DRAIN) || ((r_state == S_LOAD) && in_valid);

  // Edge lanes are zero outside LOAD, so DRAIN pushes zero padding through the array.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    assign w_a_lane[gi] = (r_state == S_LOAD) ? a_in[gi*WIDTH +: WIDTH] : '0;
    assign w_b_lane[gi] = (r_state == S_LOAD) ? b_in[gi*WIDTH +: WIDTH] : '0;
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign w_a_into[gi][gj] = w_a_lane[gi];
      end else begin : g_a_int
        assign w_a_into[gi][gj] = r_a[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign w_b_into[gi][gj] = w_b_lane[gj];
      end else begin : g_b_int
        assign w_b_into[gi][gj] = r_b[gi-1][gj];
      end
      assign w_prod[gi][gj] = w_a_into[gi][gj] * w_b_into[gi][gj];
      assign c_out[(gi*SIZE+gj)*ACC_W +: ACC_W] = r_acc[gi][gj];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every PE samples its
  // neighbour's pre-edge value; blocking here would collapse the systolic shift.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      // NOTE: the PE arrays are reset explicitly because c_out is read straight
      // from them and must show zero after reset.
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            for (int i = 0; i < SIZE; i++) begin
              for (int j = 0; j < SIZE; j++) begin
                r_a[i][j]   <= '0;
                r_b[i][j]   <= '0;
                r_acc[i][j] <= '0;
              end
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_cnt == LAST_WF) begin
              r_state <= S_DRAIN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == LAST_DR) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) begin
            r_a[i][j]   <= w_a_into[i][j];
            r_b[i][j]   <= w_b_into[i][j];
            r_acc[i][j] <= r_acc[i][j] + ACC_W'(w_prod[i][j]);
          end
        end
      end
    end
  end

endmodule
